serv_trace_buf: RTL and testbench
=================================

Name: serv_trace_buf

Overview:
Parametrised retirement-trace buffer for SERV, generalising per-instruction debug capture to any datapath width W. Each retired instruction produces one record {pc, insn, rd_addr, rd_data, rd_we}, which is pushed into a DEPTH-entry circular buffer. Records drain through a valid/ready stream.
- Capture is armed by a pulse and optionally gated by a PC-match trigger.
- When the buffer is full it either stops or overwrites the oldest record.
- Sits beside serv_top; fed from core-internal strobes and the ibus; drained by a testbench or on-chip logger.

Parameters:
W, 1, core datapath width in bits per cycle (1, 2, 4, 8, 16 or 32; must divide 32)
DEPTH, 16, number of buffer entries (power of 2, >=2)
CNT_W, 16, width of the saturating drop counter
B, W-1, derived; not to be overridden

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_ibus_adr  in  32  fetch address
i_ibus_rdt  in  32  fetched instruction
i_ibus_ack  in  1  fetch acknowledge
i_cnt_done  in  1  last cycle of instruction execution
i_ctrl_pc_en  in  1  PC update enable (retire qualifier)
i_rd_addr  in  5  destination register
i_wen0  in  1  RF write strobe
i_wdata0  in  W  RF write data slice, LSB first
i_arm  in  1  pulse: start capture
i_clear  in  1  pulse: flush buffer, zero counter, go IDLE
i_trig_en  in  1  wait for PC match before recording
i_trig_pc  in  32  trigger PC
i_wrap  in  1  1 = overwrite oldest when full, 0 = freeze
o_rec_valid  out  1  head record available
i_rec_ready  in  1  consumer accepts head
o_rec_pc  out  32  head PC
o_rec_insn  out  32  head instruction word
o_rec_rd_addr  out  5  head rd (0 if no write)
o_rec_rd_data  out  32  head rd value (0 if no write)
o_rec_rd_we  out  1  head wrote a nonzero rd
o_level  out  $clog2(DEPTH)+1  entries held
o_dropped  out  CNT_W  records lost, saturating
o_state  out  2  FSM state

Behaviour:
- Reset (i_rst_n low at a posedge) forces the following: state IDLE, read/write pointers 0, o_level 0, o_rec_valid 0, o_dropped 0, staging registers 0.
- Reset mid-operation discards all content; it has priority over every other input.
- Decode staging:
  - On i_ibus_ack, latch pc_q <= i_ibus_adr and insn_q <= i_ibus_rdt, and clear the rd_seen flag.
  - On each i_wen0 cycle: rd_q <= {i_wdata0, rd_q[31:W]}, and set rd_seen.
  - The rd value is complete after 32/W write cycles.
- Retire event R = i_cnt_done & i_ctrl_pc_en, sampled in cycle N.
  - A record is built in cycle N+1 with rd_we = rd_seen & (i_rd_addr != 0); rd_addr and rd_data are zeroed when rd_we is 0.
  - The push takes effect at the N+1 posedge; o_rec_valid is visible from cycle N+2 if the buffer was empty.
- FSM (o_state encoding: IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3):
  - IDLE: no pushes; i_arm moves to ARMED if i_trig_en, else to CAPTURE.
  - ARMED: retires are ignored until a retiring pc_q == i_trig_pc. That record is pushed and the state becomes CAPTURE.
  - CAPTURE: every retire pushes.
  - CAPTURE with buffer full at a push:
    - i_wrap=1: overwrite the oldest entry (head advances), o_dropped++.
    - i_wrap=0: discard the record, o_dropped++, enter FROZEN.
  - FROZEN: no pushes; each further retire increments o_dropped. Leaves only via i_clear.
  - i_clear in any state: pointers 0, o_dropped 0, go to IDLE. i_clear beats a simultaneous i_arm.
  - i_arm outside IDLE is ignored.
- Stream handshake:
  - A pop occurs when o_rec_valid & i_rec_ready.
  - Outputs are driven from the head entry and are stable while valid & !ready.
  - o_rec_valid = (o_level != 0).
- Simultaneous push and pop:
  - When full: a normal push, no overwrite, no drop, level unchanged.
  - When empty: the push lands and the pop does nothing (valid was 0).
- Counter: o_dropped saturates at all-ones and never wraps.
- Pointers are $clog2(DEPTH) bits and wrap naturally; o_level is one bit wider so it can represent DEPTH.

Optional Feature:
SERV_TRACE_MEM_EN
- Defined:
  - Adds ports i_dbus_adr[31:0], i_dbus_dat[31:0], i_dbus_rdt[31:0], i_dbus_sel[3:0], i_dbus_we, i_dbus_ack.
  - Adds record outputs o_rec_mem_adr[31:0], o_rec_mem_rmask[3:0], o_rec_mem_wmask[3:0], o_rec_mem_data[31:0].
  - Capture on i_dbus_ack: the adr is latched, and the mask goes to wmask if we, else rmask. Data is i_dbus_dat for stores, i_dbus_rdt for loads.
  - The masks clear on i_ibus_ack; non-memory instructions carry zero masks.
- Undefined: none of these ports or storage exist; the record width is 102 bits.

Decomposition:
- Package serv_trace_pkg holds:
  - state encodings (IDLE/ARMED/CAPTURE/FROZEN);
  - record field widths and offsets, and the packed record width (102, or 174 with MEM_EN).
- Sub-module serv_trace_fifo(DEPTH, DW):
  - circular buffer with push/pop/overwrite, full/empty, level;
  - the top level holds staging, FSM and drop counter.

Test Plan:
- W=1: ADDI x5,x0,0x123 at pc 0x100, arm with trig off -> one record {pc 0x100, insn 0x12300293, rd 5, data 0x123, we 1}; o_rec_valid 2 cycles after retire.
- W=4, 3 retires, ready held low then high -> o_level counts 1,2,3; records pop in order; o_rec_valid falls after the third pop.
- DEPTH=4, i_wrap=1, 6 retires with no reads -> o_level 4; o_dropped 2; head is the 3rd record.
- DEPTH=4, i_wrap=0, 6 retires -> records 1-4 kept; state FROZEN; o_dropped 2; i_clear -> level 0, state IDLE.
- Trigger 0x200: retires at pcs 0x1F8, 0x1FC, 0x200, 0x204 -> only 0x200 and 0x204 recorded; state ARMED then CAPTURE.
- Assert i_rst_n low while 3 records are held and pop+push coincide -> next cycle level 0, valid 0, state IDLE, dropped 0.

Source files
------------

// File: rtl/serv_trace_pkg.sv
// rtl/serv_trace_pkg.sv - shared types for the SERV retirement trace buffer
// SERV_TRACE_MEM_EN adds the data-bus fields to the record.
package serv_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_e;

    localparam int PC_W      = 32;
    localparam int INSN_W    = 32;
    localparam int RD_ADDR_W = 5;
    localparam int RD_DATA_W = 32;
`ifdef SERV_TRACE_MEM_EN
    localparam int MEM_ADR_W  = 32;
    localparam int MEM_MASK_W = 4;
    localparam int MEM_DATA_W = 32;
`endif

    // Field order fixes the packed layout: pc occupies the top bits, rd_we bit 0
    // in the base build; memory fields sit below rd_we when enabled.
    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [INSN_W-1:0]     insn;
        logic [RD_ADDR_W-1:0]  rd_addr;
        logic [RD_DATA_W-1:0]  rd_data;
        logic                  rd_we;
`ifdef SERV_TRACE_MEM_EN
        logic [MEM_ADR_W-1:0]  mem_adr;
        logic [MEM_MASK_W-1:0] mem_rmask;
        logic [MEM_MASK_W-1:0] mem_wmask;
        logic [MEM_DATA_W-1:0] mem_data;
`endif
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/serv_trace_buf_if.sv
// rtl/serv_trace_buf_if.sv - record stream between the trace buffer and its consumer
// SERV_TRACE_MEM_EN adds the memory-access record fields.
interface serv_trace_buf_if;

    logic        o_rec_valid;
    logic        i_rec_ready;
    logic [31:0] o_rec_pc;
    logic [31:0] o_rec_insn;
    logic [4:0]  o_rec_rd_addr;
    logic [31:0] o_rec_rd_data;
    logic        o_rec_rd_we;
`ifdef SERV_TRACE_MEM_EN
    logic [31:0] o_rec_mem_adr;
    logic [3:0]  o_rec_mem_rmask;
    logic [3:0]  o_rec_mem_wmask;
    logic [31:0] o_rec_mem_data;

    modport master (
        output o_rec_valid, o_rec_pc, o_rec_insn, o_rec_rd_addr, o_rec_rd_data, o_rec_rd_we,
               o_rec_mem_adr, o_rec_mem_rmask, o_rec_mem_wmask, o_rec_mem_data,
        input  i_rec_ready
    );

    modport slave (
        input  o_rec_valid, o_rec_pc, o_rec_insn, o_rec_rd_addr, o_rec_rd_data, o_rec_rd_we,
               o_rec_mem_adr, o_rec_mem_rmask, o_rec_mem_wmask, o_rec_mem_data,
        output i_rec_ready
    );
`else
    modport master (
        output o_rec_valid, o_rec_pc, o_rec_insn, o_rec_rd_addr, o_rec_rd_data, o_rec_rd_we,
        input  i_rec_ready
    );

    modport slave (
        input  o_rec_valid, o_rec_pc, o_rec_insn, o_rec_rd_addr, o_rec_rd_data, o_rec_rd_we,
        output i_rec_ready
    );
`endif

endinterface

// File: rtl/serv_trace_fifo.sv
// rtl/serv_trace_fifo.sv - circular record buffer with push, pop and overwrite-oldest
module serv_trace_fifo #(
    parameter int  DEPTH = 16,
    parameter int  DW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_overwrite,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic [LW-1:0] o_level,
    output logic          o_full
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] cnt;

    // An overwriting push advances both pointers so the level stays at DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (i_push) begin
                wptr <= wptr + AW'(1);
            end
            if ((i_push && i_overwrite) || i_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (i_push && !i_overwrite && !i_pop) begin
                cnt <= cnt + LW'(1);
            end else if (!i_push && i_pop) begin
                cnt <= cnt - LW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wptr] <= i_din;
        end
    end

    assign o_dout  = mem[rptr];
    assign o_level = cnt;
    assign o_full  = (cnt == LW'(DEPTH));

endmodule

// File: rtl/serv_trace_buf.sv
// rtl/serv_trace_buf.sv - SERV retirement trace buffer: decode staging, capture FSM, drop counter
// SERV_TRACE_MEM_EN adds data-bus capture ports and record fields.
module serv_trace_buf
    import serv_trace_pkg::*;
#(
    parameter int  W     = 1,
    parameter int  DEPTH = 16,
    parameter int  CNT_W = 16,
    localparam int B     = W - 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_ibus_adr,
    input  logic [31:0]      i_ibus_rdt,
    input  logic             i_ibus_ack,
    input  logic             i_cnt_done,
    input  logic             i_ctrl_pc_en,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_wen0,
    input  logic [B:0]       i_wdata0,
`ifdef SERV_TRACE_MEM_EN
    input  logic [31:0]      i_dbus_adr,
    input  logic [31:0]      i_dbus_dat,
    input  logic [31:0]      i_dbus_rdt,
    input  logic [3:0]       i_dbus_sel,
    input  logic             i_dbus_we,
    input  logic             i_dbus_ack,
`endif
    input  logic             i_arm,
    input  logic             i_clear,
    input  logic             i_trig_en,
    input  logic [31:0]      i_trig_pc,
    input  logic             i_wrap,
    serv_trace_buf_if.master rec,
    output logic [LW-1:0]    o_level,
    output logic [CNT_W-1:0] o_dropped,
    output logic [1:0]       o_state
);

    trace_state_e   state;
    trace_state_e   state_n;
    logic [31:0]    pc_q;
    logic [31:0]    insn_q;
    logic [31:0]    rd_q;
    logic [31:0]    rd_shift;
    logic           rd_seen;
    logic           retire_q;
    logic           rec_we;
    trace_rec_t     rec_in;
    trace_rec_t     rec_out;
    logic [LW-1:0]  fifo_level;
    logic           fifo_full;
    logic           pop;
    logic           blocked;
    logic           trig_hit;
    logic           take;
    logic           fifo_push;
    logic           fifo_ovw;
    logic           drop_inc;
    logic [CNT_W-1:0] dropped;

    // rd arrives LSB first, W bits per write strobe.
    generate
        if (W == 32) begin : g_rd_full
            assign rd_shift = i_wdata0;
        end else begin : g_rd_shift
            assign rd_shift = {i_wdata0, rd_q[31:W]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q     <= '0;
            insn_q   <= '0;
            rd_q     <= '0;
            rd_seen  <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            if (i_ibus_ack) begin
                pc_q    <= i_ibus_adr;
                insn_q  <= i_ibus_rdt;
                rd_seen <= 1'b0;
            end
            if (i_wen0) begin
                rd_q    <= rd_shift;
                rd_seen <= 1'b1;
            end
            retire_q <= i_cnt_done && i_ctrl_pc_en;
        end
    end

`ifdef SERV_TRACE_MEM_EN
    logic [31:0] mem_adr_q;
    logic [31:0] mem_data_q;
    logic [3:0]  mem_rmask_q;
    logic [3:0]  mem_wmask_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mem_adr_q   <= '0;
            mem_data_q  <= '0;
            mem_rmask_q <= '0;
            mem_wmask_q <= '0;
        end else begin
            if (i_ibus_ack) begin
                mem_rmask_q <= '0;
                mem_wmask_q <= '0;
            end
            if (i_dbus_ack) begin
                mem_adr_q <= i_dbus_adr;
                if (i_dbus_we) begin
                    mem_wmask_q <= i_dbus_sel;
                    mem_data_q  <= i_dbus_dat;
                end else begin
                    mem_rmask_q <= i_dbus_sel;
                    mem_data_q  <= i_dbus_rdt;
                end
            end
        end
    end
`endif

    // Writes to x0 and instructions without an RF write both report as "no write".
    assign rec_we = rd_seen && (i_rd_addr != 5'd0);

    always_comb begin
        rec_in         = '0;
        rec_in.pc      = pc_q;
        rec_in.insn    = insn_q;
        rec_in.rd_addr = rec_we ? i_rd_addr : 5'd0;
        rec_in.rd_data = rec_we ? rd_q : 32'd0;
        rec_in.rd_we   = rec_we;
`ifdef SERV_TRACE_MEM_EN
        rec_in.mem_adr   = mem_adr_q;
        rec_in.mem_rmask = mem_rmask_q;
        rec_in.mem_wmask = mem_wmask_q;
        rec_in.mem_data  = mem_data_q;
`endif
    end

    serv_trace_fifo #(
        .DEPTH (DEPTH),
        .DW    (REC_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_clear),
        .i_push      (fifo_push),
        .i_overwrite (fifo_ovw),
        .i_pop       (pop),
        .i_din       (rec_in),
        .o_dout      (rec_out),
        .o_level     (fifo_level),
        .o_full      (fifo_full)
    );

    assign pop      = rec.o_rec_valid && rec.i_rec_ready;
    assign trig_hit = (pc_q == i_trig_pc);
    // A pop in the same cycle frees a slot, so a full buffer only blocks without one.
    assign blocked  = fifo_full && !pop;

    always_ff @(posedge i_clk) begin : fsm_state
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin : fsm_next
        state_n = state;
        if (i_clear) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_arm) state_n = i_trig_en ? ST_ARMED : ST_CAPTURE;
                end
                ST_ARMED: begin
                    if (retire_q && trig_hit) state_n = (blocked && !i_wrap) ? ST_FROZEN : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (retire_q && blocked && !i_wrap) state_n = ST_FROZEN;
                end
                default: state_n = state;
            endcase
        end
    end

    always_comb begin : fsm_out
        take     = 1'b0;
        drop_inc = 1'b0;
        if (!i_clear && retire_q) begin
            case (state)
                ST_ARMED:   take = trig_hit;
                ST_CAPTURE: take = 1'b1;
                ST_FROZEN:  drop_inc = 1'b1;
                default:    take = 1'b0;
            endcase
            if (take && blocked) drop_inc = 1'b1;
        end
        fifo_push = take && (!blocked || i_wrap);
        fifo_ovw  = take && blocked && i_wrap;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            dropped <= '0;
        end else if (drop_inc && (dropped != '1)) begin
            dropped <= dropped + CNT_W'(1);
        end
    end

    assign rec.o_rec_valid   = (fifo_level != '0);
    assign rec.o_rec_pc      = rec_out.pc;
    assign rec.o_rec_insn    = rec_out.insn;
    assign rec.o_rec_rd_addr = rec_out.rd_addr;
    assign rec.o_rec_rd_data = rec_out.rd_data;
    assign rec.o_rec_rd_we   = rec_out.rd_we;
`ifdef SERV_TRACE_MEM_EN
    assign rec.o_rec_mem_adr   = rec_out.mem_adr;
    assign rec.o_rec_mem_rmask = rec_out.mem_rmask;
    assign rec.o_rec_mem_wmask = rec_out.mem_wmask;
    assign rec.o_rec_mem_data  = rec_out.mem_data;
`endif

    assign o_level   = fifo_level;
    assign o_dropped = dropped;
    assign o_state   = state;

endmodule

// File: tb/tb_serv_trace_buf.sv
// tb/tb_serv_trace_buf.sv - directed scoreboard bench for serv_trace_buf (W=1/DEPTH=16 and W=4/DEPTH=4)
module tb_serv_trace_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] ibus_adr, ibus_rdt, trig_pc;
    logic        ibus_ack, cnt_done, pc_en, wen0, wdata1;
    logic [4:0]  rd_addr;
    logic [3:0]  wdata4;
    logic        arm, clear, trig_en, wrap;
    logic [4:0]  level1;
    logic [15:0] drop1;
    logic [1:0]  state1;
    logic [2:0]  level4;
    logic [2:0]  drop4;
    logic [1:0]  state4;

    serv_trace_buf_if if1 ();
    serv_trace_buf_if if4 ();

    serv_trace_buf #(.W(1), .DEPTH(16), .CNT_W(16)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ibus_adr(ibus_adr), .i_ibus_rdt(ibus_rdt), .i_ibus_ack(ibus_ack),
        .i_cnt_done(cnt_done), .i_ctrl_pc_en(pc_en), .i_rd_addr(rd_addr), .i_wen0(wen0), .i_wdata0(wdata1),
        .i_arm(arm), .i_clear(clear), .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_wrap(wrap),
        .rec(if1), .o_level(level1), .o_dropped(drop1), .o_state(state1));

    serv_trace_buf #(.W(4), .DEPTH(4), .CNT_W(3)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ibus_adr(ibus_adr), .i_ibus_rdt(ibus_rdt), .i_ibus_ack(ibus_ack),
        .i_cnt_done(cnt_done), .i_ctrl_pc_en(pc_en), .i_rd_addr(rd_addr), .i_wen0(wen0), .i_wdata0(wdata4),
        .i_arm(arm), .i_clear(clear), .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_wrap(wrap),
        .rec(if4), .o_level(level4), .o_dropped(drop4), .o_state(state4));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_rec_t;

    exp_rec_t exp_q[$];
    int m_mode = 0;
    int m_drop = 0;
    int total  = 0;
    int bad    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction: fetch ack, nw RF write cycles, then the retire cycle.
    // Returns in the cycle after retire, i.e. the cycle in which the push happens.
    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                          input logic [31:0] val, input int nw);
        ibus_adr = pc;
        ibus_rdt = insn;
        ibus_ack = 1'b1;
        tick();
        ibus_ack = 1'b0;
        for (int i = 0; i < nw; i++) begin
            wen0   = 1'b1;
            wdata1 = val[i % 32];
            wdata4 = val[4*(i%8) +: 4];
            tick();
        end
        wen0     = 1'b0;
        rd_addr  = rd;
        cnt_done = 1'b1;
        pc_en    = 1'b1;
        tick();
        cnt_done = 1'b0;
        pc_en    = 1'b0;
    endtask

    task automatic model_add(input exp_rec_t r);
        if (exp_q.size() < 4) begin
            exp_q.push_back(r);
        end else begin
            m_drop = (m_drop < 7) ? m_drop + 1 : 7;
            if (wrap) begin
                void'(exp_q.pop_front());
                exp_q.push_back(r);
            end else begin
                m_mode = 3;
            end
        end
    endtask

    task automatic model_retire(input exp_rec_t r);
        case (m_mode)
            1: if (r.pc == trig_pc) begin m_mode = 2; model_add(r); end
            2: model_add(r);
            3: m_drop = (m_drop < 7) ? m_drop + 1 : 7;
            default: ;
        endcase
    endtask

    task automatic check_head(input string tag);
        exp_rec_t e;
        chk({tag, "_valid"}, if4.o_rec_valid, 1);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, if4.o_rec_pc, e.pc);
            chk({tag, "_insn"}, if4.o_rec_insn, e.insn);
            chk({tag, "_rd"}, if4.o_rec_rd_addr, e.rd);
            chk({tag, "_data"}, if4.o_rec_rd_data, e.data);
            chk({tag, "_we"}, if4.o_rec_rd_we, e.we);
        end
    endtask

    task automatic drain_one(input string tag);
        check_head(tag);
        if4.i_rec_ready = 1'b1;
        tick();
        if4.i_rec_ready = 1'b0;
    endtask

    task automatic ret4(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic [31:0] val, input int nw, input bit pop_now);
        exp_rec_t r;
        retire(pc, insn, rd, val, nw);
        r.pc   = pc;
        r.insn = insn;
        r.we   = (nw > 0) && (rd != 5'd0);
        r.rd   = r.we ? rd : 5'd0;
        r.data = r.we ? val : 32'd0;
        if (pop_now) begin
            check_head("pushpop");
            if4.i_rec_ready = 1'b1;
        end
        model_retire(r);
        tick();
        if4.i_rec_ready = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        m_mode = trig_en ? 1 : 2;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        m_mode = 0;
        m_drop = 0;
    endtask

    initial begin
        rst_n = 1'b0; ibus_adr = '0; ibus_rdt = '0; ibus_ack = 1'b0; cnt_done = 1'b0; pc_en = 1'b0;
        rd_addr = '0; wen0 = 1'b0; wdata1 = 1'b0; wdata4 = '0; arm = 1'b0; clear = 1'b0;
        trig_en = 1'b0; trig_pc = '0; wrap = 1'b0;
        if1.i_rec_ready = 1'b0;
        if4.i_rec_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_state", state4, 0);
        chk("rst_level", level4, 0);
        chk("rst_valid", if4.o_rec_valid, 0);
        chk("rst_drop", drop4, 0);
        chk("rst_valid_w1", if1.o_rec_valid, 0);

        // W=1: ADDI x5,x0,0x123 at 0x100
        arm_pulse();
        chk("w1_state", state1, 2);
        retire(32'h100, 32'h12300293, 5'd5, 32'h123, 32);
        chk("w1_valid_n1", if1.o_rec_valid, 0);
        tick();
        chk("w1_valid_n2", if1.o_rec_valid, 1);
        chk("w1_pc", if1.o_rec_pc, 32'h100);
        chk("w1_insn", if1.o_rec_insn, 32'h12300293);
        chk("w1_rd", if1.o_rec_rd_addr, 5);
        chk("w1_data", if1.o_rec_rd_data, 32'h123);
        chk("w1_we", if1.o_rec_rd_we, 1);
        chk("w1_level", level1, 1);
        clear_pulse();
        chk("w1_clr_state", state1, 0);
        chk("w1_clr_level", level1, 0);

        // W=4: three records, ready high on the first push while empty
        arm_pulse();
        if4.i_rec_ready = 1'b1;
        ret4(32'h10, 32'h00A00093, 5'd1, 32'hDEADBEEF, 8, 1'b0);
        chk("w4_level1", level4, 1);
        ret4(32'h14, 32'h00000033, 5'd0, 32'h11111111, 8, 1'b0);
        chk("w4_level2", level4, 2);
        ret4(32'h18, 32'h00008067, 5'd3, 32'hCAFEF00D, 0, 1'b0);
        chk("w4_level3", level4, 3);
        tick(); tick();
        chk("w4_hold_pc", if4.o_rec_pc, 32'h10);
        drain_one("w4_r1");
        drain_one("w4_r2");
        drain_one("w4_r3");
        chk("w4_valid_end", if4.o_rec_valid, 0);

        // Full with wrap: oldest two overwritten
        clear_pulse();
        wrap = 1'b1;
        arm_pulse();
        for (int i = 0; i < 6; i++)
            ret4(32'h40 + 32'(4*i), 32'h13 + 32'(i << 7), 5'(i + 1), 32'hA5A50000 | 32'(i), 8, 1'b0);
        chk("wrap_level", level4, 4);
        chk("wrap_drop", drop4, m_drop);
        chk("wrap_drop_const", drop4, 2);
        chk("wrap_head_pc", if4.o_rec_pc, 32'h48);
        for (int i = 0; i < 4; i++) drain_one("wrap_drain");
        chk("wrap_valid_end", if4.o_rec_valid, 0);

        // Full without wrap: freeze, then saturate the 3-bit drop counter
        clear_pulse();
        wrap = 1'b0;
        arm_pulse();
        for (int i = 0; i < 6; i++)
            ret4(32'h80 + 32'(4*i), 32'h13 + 32'(i << 7), 5'(i + 1), 32'h5A5A0000 | 32'(i), 8, 1'b0);
        chk("frz_state", state4, 3);
        chk("frz_drop", drop4, m_drop);
        chk("frz_drop_const", drop4, 2);
        chk("frz_level", level4, 4);
        chk("frz_head_pc", if4.o_rec_pc, 32'h80);
        for (int i = 0; i < 6; i++) ret4(32'hC0, 32'h13, 5'd1, 32'h0, 0, 1'b0);
        chk("sat_drop", drop4, 7);
        chk("sat_level", level4, 4);
        drain_one("frz_drain");
        chk("frz_state_after_pop", state4, 3);
        clear_pulse();
        chk("clr_level", level4, 0);
        chk("clr_state", state4, 0);
        chk("clr_drop", drop4, 0);
        chk("clr_valid", if4.o_rec_valid, 0);

        // PC trigger at 0x200
        trig_en = 1'b1;
        trig_pc = 32'h200;
        wrap    = 1'b1;
        arm_pulse();
        chk("trig_armed", state4, 1);
        ret4(32'h1F8, 32'h13, 5'd2, 32'h1, 8, 1'b0);
        ret4(32'h1FC, 32'h13, 5'd2, 32'h2, 8, 1'b0);
        chk("trig_still_armed", state4, 1);
        chk("trig_level0", level4, 0);
        ret4(32'h200, 32'h13, 5'd2, 32'h3, 8, 1'b0);
        chk("trig_capture", state4, 2);
        chk("trig_level1", level4, 1);
        ret4(32'h204, 32'h13, 5'd2, 32'h4, 8, 1'b0);
        chk("trig_level2", level4, 2);
        drain_one("trig_a");
        drain_one("trig_b");
        chk("trig_valid_end", if4.o_rec_valid, 0);
        trig_en = 1'b0;

        // Push and pop together while full, then reset mid-operation
        wrap = 1'b0;
        for (int i = 0; i < 4; i++)
            ret4(32'h300 + 32'(4*i), 32'h13, 5'd9, 32'h900 + 32'(i), 8, 1'b0);
        ret4(32'h310, 32'h13, 5'd9, 32'h904, 8, 1'b1);
        chk("pp_level", level4, 4);
        chk("pp_drop", drop4, 0);
        chk("pp_state", state4, 2);
        drain_one("pp_next");
        chk("pre_rst_level", level4, 3);
        retire(32'h320, 32'h13, 5'd7, 32'h77, 8);
        if4.i_rec_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_level", level4, 0);
        chk("mid_rst_valid", if4.o_rec_valid, 0);
        chk("mid_rst_state", state4, 0);
        chk("mid_rst_drop", drop4, 0);
        chk("mid_rst_level_w1", level1, 0);
        chk("mid_rst_drop_w1", drop1, 0);
        rst_n = 1'b1;
        if4.i_rec_ready = 1'b0;
        exp_q.delete();
        tick();
        chk("post_rst_state", state4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
